adder_scheduler: RTL
====================

ADDER_SCHEDULER -- requirements
Module: adder_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of neuron requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-003 The block SHALL have ports: clk  in  1  single clock; rising edge.
REQ-004 The block SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports: req  in  NUM_REQ  per-requester update request, level, held until grant.
REQ-006 The block SHALL have ports: req_weight  in  32*NUM_REQ  flattened input weights, slice i belongs to requester i.
REQ-007 The block SHALL have ports: req_decayed  in  32*NUM_REQ  flattened decayed potentials.
REQ-008 The block SHALL have ports: req_model  in  2*NUM_REQ  flattened model selects (00 LIF, 01 Izhikevich, 10 QLIF).
REQ-009 The block SHALL have ports: grant  out  NUM_REQ  one-hot, one-cycle pulse when request data is captured.
REQ-010 The block SHALL have ports: cfg_valid  in  1, cfg_mode  in  3, cfg_data  in  32, cfg_ready  out  1: parameter-load handshake.
REQ-011 The block SHALL have ports: adder_load  out  1, adder_init_mode  out  3, adder_time_step  out  1, adder_input_weight  out  32, adder_decayed_potential  out  32, adder_model  out  2: potential-adder drive.
REQ-012 The block SHALL have ports: adder_final_potential  in  32, adder_spike  in  1, adder_done  in  1: potential-adder results.
REQ-013 The block SHALL have ports: res_valid  out  1, res_id  out  3, res_potential  out  32, res_spike  out  1, res_error  out  1: result, one-cycle pulse.

Function
REQ-014 FSM states SHALL be IDLE, CFG_LOAD, CFG_CLR, ISSUE, WAIT, RESP.
REQ-015 IDLE: cfg_valid high SHALL take priority over any req; go to CFG_LOAD.
REQ-016 cfg_ready SHALL be high only in IDLE; cfg transfer occurs when cfg_valid and cfg_ready both high; cfg_mode 000 SHALL be ignored (stay IDLE).
REQ-017 CFG_LOAD (1 cycle): adder_load=1, adder_init_mode=captured cfg_mode, adder_input_weight=captured cfg_data; next CFG_CLR.
REQ-018 CFG_CLR (1 cycle): adder_load=0, adder_init_mode=000; next IDLE.
REQ-019 IDLE with no cfg_valid and any req high: round-robin arbitration starting at (last granted index+1) mod NUM_REQ; winner's weight, decayed, model and index SHALL be registered, grant[winner] pulsed that cycle; next ISSUE.
REQ-020 ISSUE (1 cycle): adder_time_step=1, datapath outputs=captured request values; next WAIT.
REQ-021 WAIT: adder_time_step=0, datapath outputs held; adder_done SHALL be ignored in the first WAIT cycle; when sampled high thereafter, capture adder_final_potential and adder_spike; next RESP.
REQ-022 RESP (1 cycle): res_valid=1 with res_id, res_potential, res_spike, res_error; next IDLE.
REQ-023 Minimum request-to-result latency SHALL be 4 cycles (grant cycle to res_valid), plus extra done delay.
REQ-024 req deasserted after grant SHALL have no effect on the in-flight operation; req of a new requester during busy states SHALL wait.
REQ-025 res_* outputs SHALL hold last values outside RESP; res_valid, grant, adder_load, adder_time_step SHALL be 0 outside their states.

Reset
REQ-026 rst high SHALL immediately force IDLE, all outputs 0 (cfg_ready=1 after release), round-robin pointer to requester 0 having priority.
REQ-027 Reset mid-WAIT SHALL drop the in-flight operation with no res_valid.

Configuration
REQ-028 With SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT cycles without done SHALL go to RESP with res_error=1, res_potential=0, res_spike=0.
REQ-029 Without SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely for done, and res_error SHALL be tied to 0.

Verification
REQ-030 cfg_valid=1, cfg_mode=101, cfg_data=50 -> one cycle adder_load=1/init_mode=101/weight=50, next cycle load=0/init_mode=000, then cfg_ready=1.
REQ-031 req[0]=1, weight 25, decayed 25, model 00; adder model returns done -> grant[0] pulse, time_step 1 cycle, res_valid with res_id=0 and adder's potential/spike.
REQ-032 req=1111 held continuously -> grants in order 0,1,2,3,0; no requester granted twice before others.
REQ-033 cfg_valid and req[2] high same IDLE cycle -> config load first, grant[2] after CFG_CLR.
REQ-034 SCHED_TIMEOUT_EN, TIMEOUT=255, adder_done held 0 -> res_valid with res_error=1 exactly 255 WAIT cycles after ISSUE.
REQ-035 rst asserted during WAIT -> outputs 0 asynchronously, no res_valid; next request completes normally.

Source files
------------

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter that serialises neuron update requests
// and parameter loads onto a single shared potential adder.
// Optional feature: define SCHED_TIMEOUT_EN to abort a WAIT that outlasts
// TIMEOUT cycles, reporting res_error=1 with zeroed potential and spike.
module adder_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_weight,
  input  logic [32*NUM_REQ-1:0]   req_decayed,
  input  logic [2*NUM_REQ-1:0]    req_model,
  output logic [NUM_REQ-1:0]      grant,
  input  logic                    cfg_valid,
  input  logic [2:0]              cfg_mode,
  input  logic [31:0]             cfg_data,
  output logic                    cfg_ready,
  output logic                    adder_load,
  output logic [2:0]              adder_init_mode,
  output logic                    adder_time_step,
  output logic [31:0]             adder_input_weight,
  output logic [31:0]             adder_decayed_potential,
  output logic [1:0]              adder_model,
  input  logic [31:0]             adder_final_potential,
  input  logic                    adder_spike,
  input  logic                    adder_done,
  output logic                    res_valid,
  output logic [2:0]              res_id,
  output logic [31:0]             res_potential,
  output logic                    res_spike,
  output logic                    res_error
);

  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 2;
  localparam int unsigned IDW   = 3;
  localparam int unsigned MODEW = 3;

  // Reject parameter values the arbiter and id field cannot represent
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("adder_scheduler: NUM_REQ must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_LOAD = 3'd1,
    S_CFG_CLR  = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT     = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr;
  logic [MODEW-1:0]   r_cfg_mode;
  logic [DW-1:0]      r_weight;
  logic [DW-1:0]      r_decayed;
  logic [MW-1:0]      r_model;
  logic [IDW-1:0]     r_id;
  logic               r_wait_seen;
  logic [IDW-1:0]     r_res_id;
  logic [DW-1:0]      r_res_pot;
  logic               r_res_spike;

  logic               w_arb_hit;
  logic [IDW-1:0]     w_arb_win;
  logic               w_hit_hi;
  logic [IDW-1:0]     w_idx_hi;
  logic               w_hit_lo;
  logic [IDW-1:0]     w_idx_lo;
  logic [DW-1:0]      w_sel_weight;
  logic [DW-1:0]      w_sel_decayed;
  logic [MW-1:0]      w_sel_model;
  logic               w_cfg_take;
  logic               w_grant_take;
  logic               w_done_take;
  logic               w_tmo_take;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_res_error;
`endif

  // Round-robin pick: lowest requester at or above the pointer, else lowest overall
  always_comb begin
    w_hit_hi = 1'b0;
    w_idx_hi = '0;
    w_hit_lo = 1'b0;
    w_idx_lo = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_hit_hi && req[j] && (j >= 32'(r_rr_ptr))) begin
        w_hit_hi = 1'b1;
        w_idx_hi = IDW'(j);
      end
      if (!w_hit_lo && req[j]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = IDW'(j);
      end
    end
    w_arb_hit = w_hit_lo;
    w_arb_win = w_hit_hi ? w_idx_hi : w_idx_lo;
  end

  // Select the winning requester's operand slices
  always_comb begin
    w_sel_weight  = '0;
    w_sel_decayed = '0;
    w_sel_model   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (32'(w_arb_win) == j) begin
        w_sel_weight  = req_weight[j*DW +: DW];
        w_sel_decayed = req_decayed[j*DW +: DW];
        w_sel_model   = req_model[j*MW +: MW];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and control outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_cfg_take      = 1'b0;
    w_grant_take    = 1'b0;
    w_done_take     = 1'b0;
    w_tmo_take      = 1'b0;
    grant           = '0;
    cfg_ready       = 1'b0;
    adder_load      = 1'b0;
    adder_init_mode = '0;
    adder_time_step = 1'b0;
    res_valid       = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = !rst;
        if (cfg_valid) begin
          // A config beat blocks arbitration even when its mode is a no-op
          if (cfg_mode != '0) begin
            w_cfg_take  = 1'b1;
            w_state_nxt = S_CFG_LOAD;
          end
        end else if (w_arb_hit && !rst) begin
          w_grant_take = 1'b1;
          grant        = NUM_REQ'(1) << w_arb_win;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_CFG_LOAD: begin
        adder_load      = 1'b1;
        adder_init_mode = r_cfg_mode;
        w_state_nxt     = S_CFG_CLR;
      end
      S_CFG_CLR: begin
        w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        adder_time_step = 1'b1;
        w_state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        // done is only trusted once the adder has seen a full cycle of time_step
        if (r_wait_seen && adder_done) begin
          w_done_take = 1'b1;
          w_state_nxt = S_RESP;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_tmo_take  = 1'b1;
          w_state_nxt = S_RESP;
        end
`endif
      end
      S_RESP: begin
        res_valid   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, round-robin pointer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_cfg_mode  <= '0;
      r_weight    <= '0;
      r_decayed   <= '0;
      r_model     <= '0;
      r_id        <= '0;
      r_wait_seen <= 1'b0;
      r_res_id    <= '0;
      r_res_pot   <= '0;
      r_res_spike <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_res_error <= 1'b0;
`endif
    end else begin
      r_wait_seen <= (r_state == S_WAIT);
      if (w_cfg_take) begin
        r_cfg_mode <= cfg_mode;
        r_weight   <= cfg_data;
      end
      if (w_grant_take) begin
        r_weight  <= w_sel_weight;
        r_decayed <= w_sel_decayed;
        r_model   <= w_sel_model;
        r_id      <= w_arb_win;
        r_rr_ptr  <= (32'(w_arb_win) == NUM_REQ - 1) ? '0 : w_arb_win + IDW'(1);
      end
      if (w_done_take) begin
        r_res_id    <= r_id;
        r_res_pot   <= adder_final_potential;
        r_res_spike <= adder_spike;
`ifdef SCHED_TIMEOUT_EN
        r_res_error <= 1'b0;
`endif
      end
`ifdef SCHED_TIMEOUT_EN
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
      if (w_tmo_take) begin
        r_res_id    <= r_id;
        r_res_pot   <= '0;
        r_res_spike <= 1'b0;
        r_res_error <= 1'b1;
      end
`endif
    end
  end

  assign adder_input_weight      = r_weight;
  assign adder_decayed_potential = r_decayed;
  assign adder_model             = r_model;
  assign res_id                  = r_res_id;
  assign res_potential           = r_res_pot;
  assign res_spike               = r_res_spike;
`ifdef SCHED_TIMEOUT_EN
  assign res_error               = r_res_error;
`else
  assign res_error               = 1'b0;
`endif

endmodule
